// File: rtl/rv32_alu_sequencer.sv
// rv32_alu_sequencer: multicycle initiator for the 16-bit slice adder unit.
// A 32-bit ADD/SUB/OR/AND/XOR request is split into a low-half and a high-half
// pass through the external slice. The inter-half carry is kept in a register.
// The 32-bit result and its carry/zero flags are held until the consumer takes them.
module rv32_alu_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [2:0]         i_op,
    input  logic [DATA_W-1:0]  i_operand_a,
    input  logic [DATA_W-1:0]  i_operand_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_result,
    output logic               o_carry,
    output logic               o_zero,
    output logic               o_illegal,
    output logic [SLICE_W-1:0] o_add_op_one,
    output logic [SLICE_W-1:0] o_add_op_two,
    output logic               o_add_c_in,
    output logic [1:0]         o_add_sel,
    input  logic [SLICE_W-1:0] i_add_result,
    input  logic               i_add_carry_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_AND = 2'b10;
    localparam logic [1:0] SEL_XOR = 2'b11;

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                carry_q;
    logic [DATA_W-1:0]   result_q;
    logic                carry_flag_q;
    logic                zero_q;
    logic                illegal_q;

    logic                in_op_legal;
    logic                op_is_sub;
    logic                op_is_arith;
    logic [1:0]          op_sel;

    assign in_op_legal = (i_op == OP_ADD) || (i_op == OP_SUB) || (i_op == OP_OR)
                      || (i_op == OP_AND) || (i_op == OP_XOR);
    assign op_is_sub   = (op_q == OP_SUB);
    assign op_is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // Map the captured opcode onto the slice function select
    always_comb begin
        op_sel = SEL_ADD;
        case (op_q)
            OP_OR:   op_sel = SEL_OR;
            OP_AND:  op_sel = SEL_AND;
            OP_XOR:  op_sel = SEL_XOR;
            default: op_sel = SEL_ADD;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; illegal ops jump straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    state_d = in_op_legal ? S_LO : S_DONE;
                end
            end
            S_LO:   state_d = S_HI;
            S_HI:   state_d = S_DONE;
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slice drive: low half then high half, quiet (all zero) otherwise
    always_comb begin
        o_add_op_one = '0;
        o_add_op_two = '0;
        o_add_c_in   = 1'b0;
        o_add_sel    = SEL_ADD;
        case (state_q)
            S_LO: begin
                o_add_op_one = a_q[SLICE_W-1:0];
                o_add_op_two = op_is_sub ? ~b_q[SLICE_W-1:0] : b_q[SLICE_W-1:0];
                o_add_c_in   = op_is_sub;
                o_add_sel    = op_sel;
            end
            S_HI: begin
                o_add_op_one = a_q[DATA_W-1:SLICE_W];
                o_add_op_two = op_is_sub ? ~b_q[DATA_W-1:SLICE_W] : b_q[DATA_W-1:SLICE_W];
                o_add_c_in   = op_is_arith ? carry_q : 1'b0;
                o_add_sel    = op_sel;
            end
            default: begin
                o_add_op_one = '0;
                o_add_op_two = '0;
                o_add_c_in   = 1'b0;
                o_add_sel    = SEL_ADD;
            end
        endcase
    end

    // Request capture, per-half result collection and flag generation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            result_q     <= '0;
            carry_flag_q <= 1'b0;
            zero_q       <= 1'b1;
            illegal_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        op_q      <= i_op;
                        a_q       <= i_operand_a;
                        b_q       <= i_operand_b;
                        illegal_q <= !in_op_legal;
                        if (!in_op_legal) begin
                            result_q     <= '0;
                            carry_flag_q <= 1'b0;
                            zero_q       <= 1'b1;
                        end
                    end
                end
                S_LO: begin
                    result_q[SLICE_W-1:0] <= i_add_result;
                    carry_q               <= i_add_carry_out;
                end
                S_HI: begin
                    result_q[DATA_W-1:SLICE_W] <= i_add_result;
                    carry_flag_q <= op_is_arith & i_add_carry_out;
                    zero_q       <= ({i_add_result, result_q[SLICE_W-1:0]} == '0);
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and result outputs come straight from registered state
    always_comb begin
        o_ready   = (state_q == S_IDLE) && i_rst_n;
        o_valid   = (state_q == S_DONE);
        o_result  = result_q;
        o_carry   = carry_flag_q;
        o_zero    = zero_q;
        o_illegal = illegal_q;
    end

endmodule

// File: tb/tb_rv32_alu_sequencer.sv
// Testbench for rv32_alu_sequencer with a behavioural 16-bit slice model.
// Stimulus pushes expected responses into a scoreboard. An independent monitor
// compares them against each presented result. The monitor also checks latency,
// hold stability and the quiet slice drive.
module tb_rv32_alu_sequencer;

    localparam int DATA_W  = 32;
    localparam int SLICE_W = 16;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         op;
    logic [DATA_W-1:0]  operand_a;
    logic [DATA_W-1:0]  operand_b;
    logic               res_valid;
    logic               res_ready;
    logic [DATA_W-1:0]  result;
    logic               carry;
    logic               zero;
    logic               illegal;
    logic [SLICE_W-1:0] add_op_one;
    logic [SLICE_W-1:0] add_op_two;
    logic               add_c_in;
    logic [1:0]         add_sel;
    logic [SLICE_W-1:0] add_result;
    logic               add_carry_out;
    logic [SLICE_W:0]   add_sum;

    typedef struct {
        logic [31:0] result;
        logic        carry;
        logic        zero;
        logic        illegal;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          accept_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] snap_result;
    logic        snap_carry;
    logic        snap_zero;
    logic        snap_illegal;

    rv32_alu_sequencer #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_valid         (req_valid),
        .o_ready         (req_ready),
        .i_op            (op),
        .i_operand_a     (operand_a),
        .i_operand_b     (operand_b),
        .o_valid         (res_valid),
        .i_ready         (res_ready),
        .o_result        (result),
        .o_carry         (carry),
        .o_zero          (zero),
        .o_illegal       (illegal),
        .o_add_op_one    (add_op_one),
        .o_add_op_two    (add_op_two),
        .o_add_c_in      (add_c_in),
        .o_add_sel       (add_sel),
        .i_add_result    (add_result),
        .i_add_carry_out (add_carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slice: 00 add with carry, 01 or, 10 and, 11 xor
    always_comb begin
        add_sum = {1'b0, add_op_one} + {1'b0, add_op_two} + {{SLICE_W{1'b0}}, add_c_in};
        add_result    = add_sum[SLICE_W-1:0];
        add_carry_out = add_sum[SLICE_W];
        case (add_sel)
            2'b01: begin add_result = add_op_one | add_op_two; add_carry_out = 1'b0; end
            2'b10: begin add_result = add_op_one & add_op_two; add_carry_out = 1'b0; end
            2'b11: begin add_result = add_op_one ^ add_op_two; add_carry_out = 1'b0; end
            default: begin end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got timeout expected event at cycle %0d", name, cycle);
    endtask

    // Cycle counter used to measure accept-to-valid latency
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: stamps accepts, checks presented results against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (req_valid && req_ready) accept_q.push_back(cycle);
            if (req_ready || res_valid)
                checkOutput("adder_quiet_drive",
                            32'(|{add_op_one, add_op_two, add_c_in, add_sel}), 32'd0);
            if (res_valid) begin
                checkOutput("ready_low_in_done", 32'(req_ready), 32'd0);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_output: got result %h expected no output", result);
                    end else begin
                        if (accept_q.size() == 0) failNow("accept_stamp");
                        else checkOutput("latency", 32'(cycle - accept_q.pop_front()), 32'(sb[0].lat));
                        checkOutput("result",  result,           sb[0].result);
                        checkOutput("carry",   32'(carry),       32'(sb[0].carry));
                        checkOutput("zero",    32'(zero),        32'(sb[0].zero));
                        checkOutput("illegal", 32'(illegal),     32'(sb[0].illegal));
                    end
                end else begin
                    checkOutput("hold_result",  result,        snap_result);
                    checkOutput("hold_flags",   32'({carry, zero, illegal}),
                                32'({snap_carry, snap_zero, snap_illegal}));
                end
                snap_result  <= result;
                snap_carry   <= carry;
                snap_zero    <= zero;
                snap_illegal <= illegal;
                if (res_ready && sb.size() > 0) sb.pop_front();
            end
            prev_valid <= res_valid;
        end
    end

    // Issue one request, optionally stall the consumer, then wait for drain
    task automatic applyStimulus(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                                 input logic [31:0] exp_res, input logic exp_c, input int hold);
        exp_t e;
        bit   got;
        e.illegal = (op_v > 3'd4);
        e.result  = exp_res;
        e.carry   = e.illegal ? 1'b0 : exp_c;
        e.zero    = (exp_res == 32'd0);
        e.lat     = e.illegal ? 1 : 3;
        @(posedge clk);
        #1;
        op        = op_v;
        operand_a = a_v;
        operand_b = b_v;
        req_valid = 1'b1;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (!got) failNow("accept_timeout");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (hold > 0) begin
            res_ready = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (res_valid) got = 1'b1;
            end
            if (!got) failNow("valid_timeout");
            op        = 3'b000;
            operand_a = 32'd1;
            operand_b = 32'd1;
            req_valid = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            req_valid = 1'b0;
            res_ready = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (sb.size() == 0) got = 1'b1;
        end
        if (!got) begin
            failNow("drain_timeout");
            sb.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b1;
        op        = 3'b000;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(negedge clk);
        $display("[TB] checking reset state");
        checkOutput("rst_valid",   32'(res_valid), 32'd0);
        checkOutput("rst_ready",   32'(req_ready), 32'd0);
        checkOutput("rst_result",  result,         32'd0);
        checkOutput("rst_flags",   32'({carry, zero, illegal}), 32'b010);
        checkOutput("rst_adder",   32'(|{add_op_one, add_op_two, add_c_in, add_sel}), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

        $display("[TB] directed vectors");
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 0);
        applyStimulus(3'b000, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 0);
        applyStimulus(3'b001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 0);
        applyStimulus(3'b001, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 0);
        applyStimulus(3'b001, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b1, 0);
        applyStimulus(3'b100, 32'hF0F0_1234, 32'hFFFF_0000, 32'h0F0F_1234, 1'b0, 0);
        applyStimulus(3'b010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 0);
        applyStimulus(3'b011, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 0);
        applyStimulus(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);
        applyStimulus(3'b101, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 0);
        applyStimulus(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 0);

        $display("[TB] consumer stall with ignored request");
        applyStimulus(3'b000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 10);

        $display("[TB] reset during high half");
        @(posedge clk);
        #1;
        op        = 3'b000;
        operand_a = 32'h0000_FFFF;
        operand_b = 32'h0000_0001;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hi_drive_active", 32'(add_op_two), 32'h0000_0000);
        checkOutput("hi_c_in",         32'(add_c_in),   32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(res_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
        checkOutput("mid_rst_adder", 32'(|{add_op_one, add_op_two, add_c_in, add_sel}), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("mid_rst_still_idle", 32'(res_valid), 32'd0);
        accept_q.delete();
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_mid_rst", 32'(req_ready), 32'd1);
        applyStimulus(3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 0);

        repeat (6) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
